// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST accelerator control blocks.
// Holds the MAC sequencer state encoding and the accumulator width.
package mnist_pkg;

    localparam int ACC_W = 32;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t RD   = 3'd1;
    localparam state_t ADD  = 3'd2;
    localparam state_t MUL  = 3'd3;
    localparam state_t WAIT = 3'd4;
    localparam state_t FIN  = 3'd5;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one mac_unit: reads feature/weight taps, feeds the MAC
// addend-then-multiplicand, folds each MAC result back in and reports bias + sum.
module mac_seq_ctrl
    import mnist_pkg::*;
#(
    parameter int N       = 16,
    parameter int LEN_W   = 10,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  bias,
    input  logic [ADDR_W-1:0] feat_base,
    input  logic [ADDR_W-1:0] wgt_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ACC_W-1:0]  result,
    output logic              feat_rd_en,
    output logic [ADDR_W-1:0] feat_addr,
    input  logic [N-1:0]      feat_rd_data,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [N-1:0]      wgt_rd_data,
    output logic              mac_addend_vld,
    output logic [ACC_W-1:0]  mac_addend_din,
    output logic              mac_multiplicand_vld,
    output logic [N-1:0]      mac_multiplicand_din,
    output logic [N-1:0]      mac_multiplier_din,
    input  logic [ACC_W-1:0]  mac_dout,
    input  logic              mac_dout_vld
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state, w_next_state;
    logic [LEN_W-1:0]   r_len, r_tap, w_rd_tap;
    logic [ACC_W-1:0]   r_acc, r_result, r_addend_din;
    logic [ADDR_W-1:0]  r_feat_base, r_wgt_base, r_feat_addr, r_wgt_addr;
    logic [ADDR_W-1:0]  w_feat_addr_nxt, w_wgt_addr_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [N-1:0]       r_mcand_din, r_mplier_din;
    logic               r_busy, r_done, r_err;
    logic               r_feat_rd_en, r_wgt_rd_en, r_addend_vld, r_mcand_vld;
    logic               w_accept, w_tap_last, w_timeout;
    logic               w_rd_nxt, w_add_nxt, w_mul_nxt;

    // r_busy stays high through the done cycle, so a start there is refused
    // even though the state register is already back in IDLE.
    assign w_accept   = (r_state == IDLE) && start && !r_busy;
    assign w_tap_last = (r_tap == r_len - LEN_W'(1));
    assign w_timeout  = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = (len == '0) ? FIN : RD;
            RD:   w_next_state = ADD;
            ADD:  w_next_state = MUL;
            MUL:  w_next_state = WAIT;
            WAIT: begin
                if (mac_dout_vld)   w_next_state = w_tap_last ? FIN : RD;
                else if (w_timeout) w_next_state = FIN;
            end
            FIN:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes are registered from the state being entered so they align with it.
    always_comb begin
        w_rd_nxt        = (w_next_state == RD);
        w_add_nxt       = (w_next_state == ADD);
        w_mul_nxt       = (w_next_state == MUL);
        w_rd_tap        = (r_state == IDLE) ? '0 : r_tap + LEN_W'(1);
        w_feat_addr_nxt = ((r_state == IDLE) ? feat_base : r_feat_base) + ADDR_W'(w_rd_tap);
        w_wgt_addr_nxt  = ((r_state == IDLE) ? wgt_base  : r_wgt_base)  + ADDR_W'(w_rd_tap);
    end

    // NOTE: every register here is updated with <= so all see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;  r_tap <= '0;  r_acc <= '0;  r_result <= '0;
            r_feat_base <= '0;  r_wgt_base <= '0;  r_feat_addr <= '0;  r_wgt_addr <= '0;
            r_wait_cnt <= '0;  r_addend_din <= '0;  r_mcand_din <= '0;  r_mplier_din <= '0;
            r_busy <= 1'b0;  r_done <= 1'b0;  r_err <= 1'b0;
            r_feat_rd_en <= 1'b0;  r_wgt_rd_en <= 1'b0;
            r_addend_vld <= 1'b0;  r_mcand_vld <= 1'b0;
        end else begin
            if (r_done) r_busy <= 1'b0;
            if (w_accept) begin
                r_len       <= len;
                r_acc       <= bias;
                r_tap       <= '0;
                r_feat_base <= feat_base;
                r_wgt_base  <= wgt_base;
                r_busy      <= 1'b1;
                r_err       <= 1'b0;
            end
            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                if (mac_dout_vld) begin
                    r_acc <= mac_dout;
                    if (!w_tap_last) r_tap <= r_tap + LEN_W'(1);
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == MUL) begin
                r_wait_cnt <= '0;
            end

            r_feat_rd_en <= w_rd_nxt;
            r_wgt_rd_en  <= w_rd_nxt;
            if (w_rd_nxt) begin
                r_feat_addr <= w_feat_addr_nxt;
                r_wgt_addr  <= w_wgt_addr_nxt;
            end
            r_addend_vld <= w_add_nxt;
            if (w_add_nxt) r_addend_din <= r_acc;
            r_mcand_vld <= w_mul_nxt;
            if (w_mul_nxt) begin
                r_mcand_din  <= feat_rd_data;
                r_mplier_din <= wgt_rd_data;
            end

            r_done <= (r_state == FIN);
            if (r_state == FIN) r_result <= r_acc;
        end
    end

    assign busy                 = r_busy;
    assign done                 = r_done;
    assign err                  = r_err;
    assign result               = r_result;
    assign feat_rd_en           = r_feat_rd_en;
    assign feat_addr            = r_feat_addr;
    assign wgt_rd_en            = r_wgt_rd_en;
    assign wgt_addr             = r_wgt_addr;
    assign mac_addend_vld       = r_addend_vld;
    assign mac_addend_din       = r_addend_din;
    assign mac_multiplicand_vld = r_mcand_vld;
    assign mac_multiplicand_din = r_mcand_din;
    assign mac_multiplier_din   = r_mplier_din;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized bench for mac_seq_ctrl with buffer and MAC stubs and a
// dot-product reference model (expected result, done latency, address streams).
module tb_mac_seq_ctrl;

    localparam int N       = 16;
    localparam int LEN_W   = 10;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 255;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [31:0]       bias = '0;
    logic [ADDR_W-1:0] feat_base = '0, wgt_base = '0;
    logic              busy, done, err;
    logic [31:0]       result;
    logic              feat_rd_en, wgt_rd_en;
    logic [ADDR_W-1:0] feat_addr, wgt_addr;
    logic [N-1:0]      feat_rd_data = '0, wgt_rd_data = '0;
    logic              mac_addend_vld, mac_multiplicand_vld;
    logic [31:0]       mac_addend_din;
    logic [N-1:0]      mac_multiplicand_din, mac_multiplier_din;
    logic [31:0]       mac_dout;
    logic              mac_dout_vld;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.N(N), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
        .feat_base(feat_base), .wgt_base(wgt_base),
        .busy(busy), .done(done), .err(err), .result(result),
        .feat_rd_en(feat_rd_en), .feat_addr(feat_addr), .feat_rd_data(feat_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_rd_data(wgt_rd_data),
        .mac_addend_vld(mac_addend_vld), .mac_addend_din(mac_addend_din),
        .mac_multiplicand_vld(mac_multiplicand_vld), .mac_multiplicand_din(mac_multiplicand_din),
        .mac_multiplier_din(mac_multiplier_din), .mac_dout(mac_dout), .mac_dout_vld(mac_dout_vld)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Feature / weight buffers: one-cycle read latency.
    logic [N-1:0] feat_mem [DEPTH];
    logic [N-1:0] wgt_mem  [DEPTH];
    always @(posedge clk) begin
        if (feat_rd_en) feat_rd_data <= feat_mem[feat_addr];
        if (wgt_rd_en)  wgt_rd_data  <= wgt_mem[wgt_addr];
    end

    // MAC stub: result = addend + a*b, dout_vld shown mac_lat+1 cycles after the multiplicand cycle.
    int          mac_lat  = 3;
    bit          mac_mute = 1'b0;
    logic        spur_vld = 1'b0;
    logic        stub_vld, stub_pend;
    logic [31:0] stub_addend, stub_res;
    int          stub_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_vld <= 1'b0; stub_pend <= 1'b0; stub_cnt <= 0;
            stub_addend <= '0; stub_res <= '0; mac_dout <= '0;
        end else begin
            stub_vld <= 1'b0;
            if (mac_addend_vld) stub_addend <= mac_addend_din;
            if (stub_pend) begin
                if (stub_cnt <= 1) begin
                    stub_vld  <= 1'b1;
                    mac_dout  <= stub_res;
                    stub_pend <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
            if (mac_multiplicand_vld && !mac_mute) begin
                stub_pend <= 1'b1;
                stub_cnt  <= mac_lat;
                stub_res  <= stub_addend + 32'(mac_multiplicand_din) * 32'(mac_multiplier_din);
            end
        end
    end
    assign mac_dout_vld = stub_vld | spur_vld;

    // Passive monitors sampled on the falling edge.
    int cyc = 0, done_cnt = 0, rd_cnt = 0, mac_cnt = 0, order_err = 0;
    int feat_aq[$], wgt_aq[$];
    logic prev_add = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (feat_rd_en) begin feat_aq.push_back(int'(feat_addr)); rd_cnt++; end
        if (wgt_rd_en)  wgt_aq.push_back(int'(wgt_addr));
        if (mac_addend_vld) mac_cnt++;
        if (mac_multiplicand_vld) mac_cnt++;
        if (mac_multiplicand_vld != prev_add) order_err++;
        prev_add = mac_addend_vld;
    end

    function automatic logic [31:0] ref_dot(input int n, input logic [31:0] b, input int fb, input int wb);
        logic [31:0] acc = b;
        for (int i = 0; i < n; i++)
            acc = acc + 32'(feat_mem[(fb + i) % DEPTH]) * 32'(wgt_mem[(wb + i) % DEPTH]);
        return acc;
    endfunction

    task automatic run_op(input string tag, input int n, input logic [31:0] b, input int fb,
                          input int wb, input int lat, input bit mute, input bit busy_start,
                          input bit spur);
        int          s, exp_lat, exp_rd, d0, r0, m0;
        logic [31:0] exp_res;
        bit          seen = 1'b0;
        exp_res = mute ? b : ref_dot(n, b, fb, wb);
        exp_lat = (n == 0) ? 2 : (mute ? 3 + TIMEOUT + 2 : n * (4 + lat) + 2);
        exp_rd  = (n == 0) ? 0 : (mute ? 1 : n);
        mac_lat = lat; mac_mute = mute;
        @(negedge clk);
        feat_aq.delete(); wgt_aq.delete();
        d0 = done_cnt; r0 = rd_cnt; m0 = mac_cnt;
        s = cyc;
        len = LEN_W'(n); bias = b; feat_base = ADDR_W'(fb); wgt_base = ADDR_W'(wb); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
        for (int k = 0; k < exp_lat + 40; k++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy_start && cyc == s + 5) begin
                start = 1'b1; len = 5; bias = 32'hdead; feat_base = '0; wgt_base = '0;
            end else begin
                start = 1'b0;
            end
            spur_vld = spur && feat_rd_en;
            @(negedge clk);
        end
        start = 1'b0; spur_vld = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, cyc - s, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, err, mute);
        check({tag, "_busy_at_done"}, busy, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_off"}, busy, 0);
        repeat (4) @(negedge clk);
        check({tag, "_single_done"}, done_cnt - d0, 1);
        check({tag, "_rd_count"}, rd_cnt - r0, exp_rd);
        check({tag, "_mac_strobes"}, mac_cnt - m0, 2 * exp_rd);
        check({tag, "_addr_count"}, feat_aq.size() + wgt_aq.size(), 2 * exp_rd);
        for (int i = 0; i < feat_aq.size() && i < wgt_aq.size(); i++) begin
            check({tag, "_feat_addr"}, feat_aq[i], (fb + i) % DEPTH);
            check({tag, "_wgt_addr"},  wgt_aq[i],  (wb + i) % DEPTH);
        end
        check({tag, "_strobe_order"}, order_err, 0);
    endtask

    initial begin
        int d0, fb, wb;
        for (int i = 0; i < DEPTH; i++) begin
            feat_mem[i] = N'($urandom);
            wgt_mem[i]  = N'($urandom);
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", |{busy, done, err, result, feat_rd_en, feat_addr, wgt_rd_en, wgt_addr,
                                 mac_addend_vld, mac_addend_din, mac_multiplicand_vld,
                                 mac_multiplicand_din, mac_multiplier_din}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 3-tap dot product
        feat_mem[100] = 1; feat_mem[101] = 2; feat_mem[102] = 3;
        wgt_mem[200]  = 4; wgt_mem[201]  = 5; wgt_mem[202]  = 6;
        run_op("basic", 3, 32'd10, 100, 200, 3, 1'b0, 1'b0, 1'b0);
        check("basic_is_42", result, 42);

        run_op("len0", 0, 32'h1234, 7, 9, 3, 1'b0, 1'b0, 1'b0);
        check("len0_is_1234", result, 32'h1234);

        run_op("wrap", 4, $urandom, 1022, 0, 2, 1'b0, 1'b0, 1'b0);

        run_op("timeout", 2, 32'h55, 300, 400, 3, 1'b1, 1'b0, 1'b0);
        feat_mem[50] = 1; wgt_mem[60] = 1;
        run_op("after_to", 1, 32'd0, 50, 60, 2, 1'b0, 1'b0, 1'b0);
        check("after_to_is_1", result, 1);

        run_op("busy_spur", 3, $urandom, 500, 600, 2, 1'b0, 1'b1, 1'b1);

        // Reset during WAIT of tap 1, then a fresh run.
        mac_lat = 4; mac_mute = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        len = 3; bias = 32'h77; feat_base = 10; wgt_base = 20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0, m = 0; k < 200 && m < 2; k++) begin
            if (mac_multiplicand_vld) m++;
            if (m < 2) @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", |{busy, done, err, result, feat_rd_en, feat_addr, wgt_rd_en, wgt_addr,
                                   mac_addend_vld, mac_addend_din, mac_multiplicand_vld,
                                   mac_multiplicand_din, mac_multiplier_din}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        run_op("after_rst", 2, $urandom, 30, 40, 3, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            fb = $urandom_range(0, DEPTH - 1);
            wb = $urandom_range(0, DEPTH - 1);
            run_op("rand", $urandom_range(1, 6), $urandom, fb, wb, $urandom_range(1, 5),
                   1'b0, 1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
